imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port (read-only) and its data port (LD/SD).
- One transaction is outstanding at a time. The data port has priority, and a starvation guard keeps fetch moving.
- Ack and err are returned to the requesting stage. A memory timeout terminates a hung access with an error, so the pipeline never deadlocks.
- Sits between the IF/MEM stages and the memory model; the IF/MEM stages stall while their req is high without ack.

Parameters:
- ADDR_W, 64, byte address width on all ports.
- DATA_W, 64, data width on all ports.
- STARVE_MAX, 4, consecutive data grants taken while fetch was requesting before fetch is forced to win (1..15).
- TIMEOUT, 255, number of WAIT cycles without mem_ack before the transaction is aborted with err (1..65535).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle completion pulse.
- if_rdata  out  DATA_W  fetch data, valid with if_ack.
- if_err  out  1  timeout flag, valid with if_ack.
- dm_req  in  1  data request, held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_ack  out  1  one-cycle completion pulse.
- dm_rdata  out  DATA_W  load data, valid with dm_ack (0 for stores).
- dm_err  out  1  timeout flag, valid with dm_ack.
- mem_req  out  1  one-cycle memory command strobe.
- mem_we  out  1  write enable, valid with mem_req.
- mem_addr  out  ADDR_W  memory address, valid with mem_req.
- mem_wdata  out  DATA_W  write data, valid with mem_req.
- mem_ack  in  1  one-cycle completion pulse; arrives at least 1 cycle after mem_req.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, any time including mid-transaction):
  - state = IDLE, starve_cnt = 0, timeout counter = 0.
  - All outputs are 0.
  - An in-flight mem_ack arriving after reset is ignored.
- All outputs are registered.
- States and transitions:
  - IDLE: sample requests.
    - dm_req only → grant D.
    - if_req only → grant I.
    - Both → grant D, unless starve_cnt == STARVE_MAX, then grant I.
    - On any grant: latch port id, we, addr, wdata; go to ISSUE.
    - Neither → stay in IDLE.
    - mem_ack is ignored in IDLE.
  - ISSUE: exactly one cycle.
    - mem_req = 1 with latched we/addr/wdata; mem_we = 0 for I grants.
    - Clear the timeout counter; go to WAIT.
    - mem_ack in this cycle is a protocol violation and is ignored.
  - WAIT:
    - mem_ack → capture mem_rdata (forced to 0 if the transaction is a store), err = 0; go to RESP.
    - Otherwise increment the timeout counter. When it reaches TIMEOUT: rdata = 0, err = 1; go to RESP.
    - A late mem_ack arriving after the abort is ignored.
  - RESP: exactly one cycle.
    - Drive the granted port's ack = 1 together with its rdata/err. The other port's ack stays 0.
    - Go to IDLE.
- Handshake:
  - A requester holds req and its payload stable until it sees ack.
  - It may drop req, or present a new request, in the cycle after ack. Because IDLE follows RESP, no double issue can occur.
  - req dropped before ack is a requester error; the transaction still completes and is acked.
- Latency: request seen in IDLE at cycle 0 → mem_req at cycle 1 → port ack at cycle L+2, where L (≥1) is the memory latency in cycles. Minimum is 3 cycles.
- Starvation guard:
  - At each arbitration in IDLE with both requesting and D granted: starve_cnt += 1, saturating at STARVE_MAX.
  - Any I grant clears starve_cnt to 0.
  - A D grant with if_req low leaves starve_cnt unchanged.
- Width rules:
  - Addresses pass through unmodified; the memory does word indexing.
  - Counters are sized to hold the maximum value of their parameter.

Decomposition:
- Package riscv_mem_pkg:
  - State encoding: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3.
  - Port ids: PORT_I = 1'b0, PORT_D = 1'b1.
- One sub-module, mem_timeout_counter: clear / enable / expired output, parameter TIMEOUT.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Single fetch: if_req, addr = 0x40; memory returns 0x0000_0000_0030_0093 after L = 2.
  - mem_req at cycle 1 with mem_we = 0, addr 0x40.
  - if_ack at cycle 4 with that data and if_err = 0.
  - dm_ack stays 0 throughout.
- Store: dm_req, dm_we = 1, addr 0x100, wdata 0xDEAD_BEEF.
  - mem_req with mem_we = 1 and the same addr/wdata.
  - dm_ack with dm_rdata = 0.
- Simultaneous: if_req and dm_req held continuously, STARVE_MAX = 4.
  - Grant order is D, D, D, D, I, D, ...
  - starve_cnt reads 0 after the I grant.
- Timeout: TIMEOUT = 8, memory never acks a load.
  - dm_ack at cycle 1 + 8 + 1 = cycle 10 with dm_err = 1, dm_rdata = 0.
  - A mem_ack injected at cycle 12 produces no ack.
- Reset mid-WAIT: assert reset asynchronously between clock edges.
  - All outputs read 0 immediately, busy = 0.
  - A subsequent mem_ack is ignored.
  - The next if_req is served normally.
- Back-to-back: the requester presents a new dm_req in the cycle after dm_ack.
  - Exactly one mem_req per transaction; the second mem_req arrives 1 cycle after IDLE.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified-memory arbiter:
// FSM state encoding and requester port ids.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts WAIT cycles without a memory ack.
// Ports: clock/reset, clear_i, en_i, expired_o (high in the cycle
// whose increment would reach TIMEOUT).
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && cnt_q != CW'(TIMEOUT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one single-ported memory between fetch (I) and data (D).
// Ports: if_* fetch, dm_* data, mem_* memory side, busy; all outputs registered.
module imem_dmem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  port_id_e          port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;

  logic              resp_go;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              to_clear;
  logic              to_en;
  logic              to_expired;

  logic              if_ack_q, dm_ack_q, if_err_q, dm_err_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              mem_req_q, busy_q;

  assign to_clear = (state_q == ISSUE);
  assign to_en    = (state_q == WAIT) && !mem_ack;

  mem_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (to_clear),
    .en_i     (to_en),
    .expired_o(to_expired)
  );

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    starve_cnt_d = starve_cnt_q;
    resp_go      = 1'b0;
    resp_rdata   = '0;
    resp_err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Fetch wins only when D is idle or fetch has been starved.
        if (if_req && (!dm_req || starve_cnt_q == SMAX)) begin
          port_d       = PORT_I;
          we_d         = 1'b0;
          addr_d       = if_addr;
          wdata_d      = '0;
          starve_cnt_d = '0;
          state_d      = ISSUE;
        end else if (dm_req) begin
          port_d  = PORT_D;
          we_d    = dm_we;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          if (if_req && starve_cnt_q != SMAX) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
          end
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_ack) begin
          resp_go    = 1'b1;
          resp_rdata = we_q ? '0 : mem_rdata;
          state_d    = RESP;
        end else if (to_expired) begin
          resp_go  = 1'b1;
          resp_err = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      port_q       <= PORT_I;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      starve_cnt_q <= '0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      dm_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      mem_req_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      starve_cnt_q <= starve_cnt_d;
      if_ack_q     <= resp_go && port_q == PORT_I;
      dm_ack_q     <= resp_go && port_q == PORT_D;
      if_err_q     <= resp_go && port_q == PORT_I && resp_err;
      dm_err_q     <= resp_go && port_q == PORT_D && resp_err;
      if_rdata_q   <= (resp_go && port_q == PORT_I) ? resp_rdata : '0;
      dm_rdata_q   <= (resp_go && port_q == PORT_D) ? resp_rdata : '0;
      mem_req_q    <= (state_d == ISSUE);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign dm_err    = dm_err_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter (TIMEOUT=8, STARVE_MAX=4).
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_imem_dmem_arbiter;

  logic        clock, reset;
  logic        if_req, if_ack, if_err;
  logic [63:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ack, dm_err;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack, busy;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  imem_dmem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .STARVE_MAX(4), .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .dm_err(dm_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic seen;
  int   n;
  logic [63:0] exp_addr;
  logic        exp_d;
  logic [4:0]  order;

  initial begin
    reset = 1'b0; if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_ctl", {57'd0, if_ack, if_err, dm_ack, dm_err,
                    mem_req, mem_we, busy}, 64'd0);
    chk("rst_dat", if_rdata | dm_rdata | mem_addr | mem_wdata, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Single fetch, L = 2
    if_req = 1; if_addr = 64'h40;
    tick();
    chk("f_req", {mem_req, mem_we}, 2'b10);
    chk("f_addr", mem_addr, 64'h40);
    seen = dm_ack;
    tick();
    chk("f_early", if_ack, 0);
    seen |= dm_ack;
    tick();
    mem_ack = 1; mem_rdata = 64'h0000_0000_0030_0093;
    chk("f_early2", if_ack, 0);
    tick();
    mem_ack = 0;
    seen |= dm_ack;
    chk("f_ack", if_ack, 1);
    chk("f_data", if_rdata, 64'h0000_0000_0030_0093);
    chk("f_err", if_err, 0);
    chk("f_dm", seen, 0);
    if_req = 0;
    tick();
    chk("f_idle", {if_ack, busy}, 0);

    // Store (L = 1) followed by back-to-back load
    dm_req = 1; dm_we = 1; dm_addr = 64'h100; dm_wdata = 64'hDEAD_BEEF;
    tick();
    chk("s_req", {mem_req, mem_we}, 2'b11);
    chk("s_addr", mem_addr, 64'h100);
    chk("s_wdata", mem_wdata, 64'hDEAD_BEEF);
    tick();
    mem_ack = 1; mem_rdata = 64'h1234;
    tick();
    mem_ack = 0;
    chk("s_ack", {dm_ack, dm_err, if_ack}, 3'b100);
    chk("s_rdata", dm_rdata, 0);
    dm_we = 0; dm_addr = 64'h108;
    tick();
    chk("b_gap", {mem_req, busy}, 0);
    tick();
    chk("b_req", {mem_req, mem_we}, 2'b10);
    chk("b_addr", mem_addr, 64'h108);
    tick();
    chk("b_one", mem_req, 0);
    mem_ack = 1; mem_rdata = 64'hCAFE;
    tick();
    mem_ack = 0;
    chk("b_ack", dm_ack, 1);
    chk("b_data", dm_rdata, 64'hCAFE);
    dm_req = 0;
    tick();

    // Simultaneous requests: D D D D I D
    order = 5'b01111;
    if_req = 1; if_addr = 64'h200;
    dm_req = 1; dm_we = 0; dm_addr = 64'h300;
    for (int k = 0; k < 6; k++) begin
      exp_d = (k == 4) ? 1'b0 : 1'b1;
      exp_addr = exp_d ? 64'h300 : 64'h200;
      n = 0;
      tick();
      while (!mem_req && n < 10) begin
        tick();
        n++;
      end
      chk("g_req", mem_req, 1);
      chk("g_addr", mem_addr, exp_addr);
      if (k == 4) chk("g_starve0", 64'(dut.starve_cnt_q), 0);
      if (k == 3) chk("g_starve4", 64'(dut.starve_cnt_q), 4);
      tick();
      mem_ack = 1; mem_rdata = exp_d ? 64'h2222 : 64'h1111;
      tick();
      mem_ack = 0;
      chk("g_ack", {if_ack, dm_ack}, exp_d ? 2'b01 : 2'b10);
      chk("g_data", exp_d ? dm_rdata : if_rdata,
          exp_d ? 64'h2222 : 64'h1111);
      if (k == 5) begin
        if_req = 0; dm_req = 0;
      end
    end
    tick();
    tick();

    // Timeout: load never acked
    dm_req = 1; dm_we = 0; dm_addr = 64'h400;
    tick();
    chk("t_req", mem_req, 1);
    seen = 0;
    for (int c = 2; c <= 9; c++) begin
      tick();
      seen |= dm_ack | mem_req;
    end
    chk("t_quiet", seen, 0);
    tick();
    chk("t_ack", {dm_ack, dm_err}, 2'b11);
    chk("t_rdata", dm_rdata, 0);
    dm_req = 0;
    tick();
    tick();
    mem_ack = 1; mem_rdata = 64'hBAD;
    tick();
    mem_ack = 0;
    chk("t_late", {if_ack, dm_ack, mem_req, busy}, 0);
    tick();
    chk("t_late2", {if_ack, dm_ack, mem_req, busy}, 0);

    // Asynchronous reset in WAIT
    if_req = 1; if_addr = 64'h500;
    tick();
    tick();
    chk("r_busy", busy, 1);
    #3 reset = 1'b1;
    #1;
    chk("r_ctl", {57'd0, if_ack, if_err, dm_ack, dm_err,
                  mem_req, mem_we, busy}, 64'd0);
    chk("r_dat", if_rdata | dm_rdata | mem_addr | mem_wdata, 64'd0);
    if_req = 0;
    #2 reset = 1'b0;
    tick();
    mem_ack = 1; mem_rdata = 64'h99;
    tick();
    mem_ack = 0;
    chk("r_stale", {if_ack, dm_ack, busy}, 0);
    tick();
    chk("r_stale2", {if_ack, dm_ack, mem_req}, 0);
    if_req = 1; if_addr = 64'h508;
    tick();
    chk("r_req", mem_req, 1);
    chk("r_addr", mem_addr, 64'h508);
    tick();
    mem_ack = 1; mem_rdata = 64'h77;
    tick();
    mem_ack = 0;
    chk("r_ack", {if_ack, if_err}, 2'b10);
    chk("r_data", if_rdata, 64'h77);
    if_req = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
